pulse_echo_receiver: RTL and testbench

Receive side of the pulse propagation time meter. The block is armed by the launch strobe from the impulse generator. It synchronizes the asynchronous returning pulse, detects its rising edge, and reports the propagation time in clock cycles. If the pulse never returns within a window, it reports a timeout instead.

---
 rtl/pulse_meter_pkg.sv | 13 +
 rtl/sync_rise_detect.sv | 29 ++
 rtl/pulse_echo_receiver.sv | 108 ++++++++++
 tb/tb_pulse_echo_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and default parameters for the pulse propagation time meter.
package pulse_meter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int COUNT_W_DFLT        = 16;
  localparam int SYNC_STAGES_DFLT    = 2;
  localparam int TIMEOUT_CYCLES_DFLT = 50000;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by a prev-sample
// flop that yields a one-cycle strobe on each rising edge of the synchronized level.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_echo_receiver.sv
// Receive side of the pulse propagation time meter: armed by the launch strobe,
// measures cycles until the synchronized echo rises, or flags a timeout.
//
// state | meaning
// IDLE  | waiting for a rising edge on i_Start; o_Ready high
// COUNT | counting cycles since launch; waiting for echo edge or window end
module pulse_echo_receiver
  import pulse_meter_pkg::*;
#(
  parameter int COUNT_W        = COUNT_W_DFLT,
  parameter int SYNC_STAGES    = SYNC_STAGES_DFLT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Start,
  input  logic               i_Echo,
  output logic [COUNT_W-1:0] o_Time,
  output logic               o_Valid,
  output logic               o_Timeout,
  output logic               o_Ready
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_echo_receiver: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << COUNT_W)) begin : g_bad_window
    $error("pulse_echo_receiver: TIMEOUT_CYCLES out of range for COUNT_W");
  end

  localparam logic [COUNT_W:0]   SYNC_EXT = (COUNT_W+1)'(SYNC_STAGES);
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] cnt, cnt_nxt;
  logic [COUNT_W-1:0] time_nxt;
  logic               valid_nxt;
  logic               timeout_nxt;
  logic               start_prev;
  logic               start_rise;
  logic               echo_rise;
  logic               unused_echo_level;
  logic [COUNT_W:0]   cnt_inc;

  sync_rise_detect #(
    .STAGES (SYNC_STAGES)
  ) u_echo_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .din   (i_Echo),
    .level (unused_echo_level),
    .rise  (echo_rise)
  );

  assign start_rise = i_Start & ~start_prev;
  assign cnt_inc    = {1'b0, cnt} + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      cnt        <= '0;
      o_Time     <= '0;
      o_Valid    <= 1'b0;
      o_Timeout  <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_Time     <= time_nxt;
      o_Valid    <= valid_nxt;
      o_Timeout  <= timeout_nxt;
      start_prev <= i_Start;
    end
  end

  // An echo edge seen before cnt+1 reaches SYNC_STAGES entered the synchronizer
  // before the launch edge, so it is skipped rather than reported.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    time_nxt    = o_Time;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        cnt_nxt = cnt_inc[COUNT_W-1:0];
        if (echo_rise && (cnt_inc >= SYNC_EXT)) begin
          time_nxt  = COUNT_W'(cnt_inc - SYNC_EXT);
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_Ready = (state == IDLE);

endmodule

// File: tb/tb_pulse_echo_receiver.sv
// Scoreboard bench for pulse_echo_receiver: stimulus pushes expected strobes,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_pulse_echo_receiver;

  localparam int CW = 16;

  typedef struct {
    bit          is_to;
    logic [15:0] t;
    int          at;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          echo;
  logic [CW-1:0] o_time;
  logic          o_valid;
  logic          o_timeout;
  logic          o_ready;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   last_time = 0;
  exp_t q[$];

  pulse_echo_receiver #(
    .COUNT_W        (CW),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Start   (start),
    .i_Echo    (echo),
    .o_Time    (o_time),
    .o_Valid   (o_valid),
    .o_Timeout (o_timeout),
    .o_Ready   (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_timeout)) begin
      chk("strobe_exclusive", int'(o_valid && o_timeout), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b timeout=%0b time=%0d at edge %0d, expected no strobe",
                 o_valid, o_timeout, o_time, edge_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", int'({o_valid, o_timeout}), e.is_to ? 1 : 2);
        chk("strobe_edge", edge_cnt, e.at);
        chk("o_time", int'(o_time), int'(e.t));
        chk("ready_on_strobe", int'(o_ready), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(output int k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = edge_cnt;
  endtask

  // Raise echo so it is first sampled high on edge k+d: expected time d, strobe after edge k+d+2.
  task automatic echo_at(input int k, input int d);
    while (edge_cnt < k + d - 1) @(negedge clk);
    echo = 1'b1;
    q.push_back('{is_to: 1'b0, t: 16'(d), at: k + d + 2});
    last_time = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int k, k2;
    rst_n = 1'b0;
    start = 1'b0;
    echo  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_ready", int'(o_ready), 1);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_timeout", int'(o_timeout), 0);
    chk("reset_time", int'(o_time), 0);

    // basic measurement
    launch(k);
    chk("ready_after_start", int'(o_ready), 0);
    echo_at(k, 25);
    tick(4);
    echo = 1'b0;
    chk("ready_after_valid", int'(o_ready), 1);
    tick(5);

    // timeout, then re-arm on the strobe cycle
    launch(k);
    q.push_back('{is_to: 1'b1, t: 16'(last_time), at: k + 100});
    tick(100);
    launch(k2);
    chk("rearm_after_timeout", int'(o_ready), 0);
    echo_at(k2, 7);
    tick(4);
    echo = 1'b0;
    tick(5);

    // echo already high before start
    echo = 1'b1;
    tick(1);
    launch(k);
    tick(4);
    echo = 1'b0;
    echo_at(k, 20);
    tick(4);
    echo = 1'b0;
    tick(5);

    // echo edge on the timeout edge: echo wins
    launch(k);
    echo_at(k, 98);
    tick(4);
    echo = 1'b0;
    tick(5);

    // echo pulses while idle
    repeat (3) begin
      echo = 1'b1;
      tick(4);
      echo = 1'b0;
      tick(4);
    end
    chk("idle_ready", int'(o_ready), 1);

    // extra starts during COUNT are ignored
    launch(k);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_extra_start", int'(o_ready), 0);
    echo_at(k, 30);
    tick(4);
    echo = 1'b0;
    tick(5);

    // asynchronous reset mid-measurement
    launch(k);
    tick(7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(o_ready), 1);
    chk("midrst_time", int'(o_time), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_timeout", int'(o_timeout), 0);
    last_time = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    echo = 1'b1;
    tick(10);
    echo = 1'b0;
    tick(3);

    // back-to-back: start on the o_Valid cycle
    launch(k);
    echo_at(k, 12);
    tick(2);
    echo = 1'b0;
    tick(1);
    launch(k2);
    echo_at(k2, 3);
    tick(4);
    echo = 1'b0;
    tick(5);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
